delay_mem_arbiter: RTL and testbench

//  Shares the single delay-memory port between the two pipeline instances (live and staging).

---
 rtl/delay_mem_arbiter_pkg.sv | 23 ++
 rtl/delay_mem_arbiter_if.sv | 27 ++
 rtl/delay_mem_arbiter_req_tag_fifo.sv | 60 ++++++
 rtl/delay_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_delay_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_mem_arbiter_pkg.sv
// Shared definitions for the delay-memory arbiter: widths, default depths and the
// requester-id encoding used for grants, tags and read-return routing.
package delay_mem_arbiter_pkg;

    localparam int DELAY_MEM_ADDR_WIDTH = 24;
    localparam int DELAY_MEM_DATA_WIDTH = 16;
    localparam int DEFAULT_MAX_READS    = 8;
    localparam int DEFAULT_STARVE_LIMIT = 16;

    typedef enum logic {
        PIPE_0 = 1'b0,
        PIPE_1 = 1'b1
    } pipe_id_e;

    function automatic logic [1:0] pipe_onehot(input pipe_id_e id);
        return (id == PIPE_1) ? 2'b10 : 2'b01;
    endfunction

    function automatic pipe_id_e other_pipe(input pipe_id_e id);
        return (id == PIPE_1) ? PIPE_0 : PIPE_1;
    endfunction

endpackage

// File: rtl/delay_mem_arbiter_if.sv
// Delay-memory access port: registered request toward memory plus in-order read return.
interface delay_mem_arbiter_if
    import delay_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DELAY_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DELAY_MEM_DATA_WIDTH
) ();

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/delay_mem_arbiter_req_tag_fifo.sv
// Requester-id FIFO: one entry per read in flight, popped as memory returns data in order.
module req_tag_fifo
    import delay_mem_arbiter_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_MAX_READS,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  pipe_id_e         din,
    output pipe_id_e         dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    pipe_id_e         slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = slots[rd_ptr];

    // NOTE: the entry array is deliberately not reset; pointers and count alone decide validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= din;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/delay_mem_arbiter.sv
// Shares one delay-memory port between the live and staging pipelines: priority arbitration
// with a starvation guard, a single registered output slot, and tag-routed read returns.
module delay_mem_arbiter
    import delay_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DELAY_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DELAY_MEM_DATA_WIDTH,
    parameter int MAX_READS    = DEFAULT_MAX_READS,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    current_pipeline,
    input  logic [1:0]              req,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              gnt,
    output logic [1:0]              rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    delay_mem_arbiter_if.master     mem,
    output logic                    err_spurious
);

    localparam int CTR_W = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W = $clog2(MAX_READS) + 1;

    pipe_id_e              live_id;
    pipe_id_e              stg_id;
    pipe_id_e              grant_id;
    logic                  grant_any;
    logic                  slot_free;
    logic                  starved;
    logic [1:0]            eligible;
    logic [CTR_W-1:0]      starve_ctr;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  push_tag;
    logic                  pop_tag;
    pipe_id_e              tag_dout;
    logic [CNT_W-1:0]      tag_count;
    logic                  tag_full;
    logic                  tag_empty;

    assign live_id   = pipe_id_e'(current_pipeline);
    assign stg_id    = other_pipe(live_id);
    assign slot_free = !mem.mem_req || mem.mem_ready;
    assign starved   = (starve_ctr == CTR_W'(STARVE_LIMIT));

    // Writes never need a tag, so only reads are held back by a full tag FIFO.
    assign eligible  = req & (req_we | {2{!tag_full}});

    always_comb begin
        // NOTE: defaults come first so every path assigns every output and no latch is inferred.
        grant_any = 1'b0;
        grant_id  = live_id;
        gnt       = 2'b00;
        if (!reset && slot_free && (eligible != 2'b00)) begin
            grant_any = 1'b1;
            if (eligible[stg_id] && (!eligible[live_id] || starved)) begin
                grant_id = stg_id;
            end
            gnt = pipe_onehot(grant_id);
        end
    end

    assign sel_we    = (grant_id == PIPE_1) ? req_we[1] : req_we[0];
    assign sel_addr  = (grant_id == PIPE_1) ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                            : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = (grant_id == PIPE_1) ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                            : req_wdata[DATA_WIDTH-1:0];

    // A loaded access is held untouched until memory takes it; a grant only happens once the
    // slot is free, so loading and holding never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else if (grant_any) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= sel_we;
            mem.mem_addr  <= sel_addr;
            mem.mem_wdata <= sel_wdata;
        end else if (mem.mem_ready) begin
            mem.mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_ctr <= '0;
        end else if (req[stg_id] && !gnt[stg_id]) begin
            if (!starved) begin
                starve_ctr <= starve_ctr + CTR_W'(1);
            end
        end else begin
            starve_ctr <= '0;
        end
    end

    assign push_tag = grant_any && !sel_we;
    assign pop_tag  = mem.mem_rvalid && !tag_empty;

    req_tag_fifo #(
        .DEPTH (MAX_READS)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_tag),
        .pop   (pop_tag),
        .din   (grant_id),
        .dout  (tag_dout),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid       <= 2'b00;
            rdata        <= '0;
            err_spurious <= 1'b0;
        end else begin
            rvalid       <= pop_tag ? pipe_onehot(tag_dout) : 2'b00;
            err_spurious <= mem.mem_rvalid && tag_empty;
            if (pop_tag) begin
                rdata <= mem.mem_rdata;
            end
        end
    end

    a_tag_count_bound: assert property (@(posedge clk) disable iff (reset)
        tag_count <= CNT_W'(MAX_READS));

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));

endmodule

// File: tb/tb_delay_mem_arbiter.sv
// Directed bench for delay_mem_arbiter with a queue-based reference model checked every cycle.
module tb_delay_mem_arbiter;
    import delay_mem_arbiter_pkg::*;

    localparam int AW    = 24;
    localparam int DW    = 16;
    localparam int MAXR  = 8;
    localparam int LIMIT = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            current_pipeline = 1'b0;
    logic [1:0]      req = 2'b00;
    logic [1:0]      req_we = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            err_spurious;

    logic            man_rvalid = 1'b0;
    logic [DW-1:0]   man_rdata = '0;
    logic            auto_ret = 1'b0;
    logic            auto_rvalid = 1'b0;
    logic [DW-1:0]   auto_rdata = '0;
    logic [DW-1:0]   ret_seq = 16'h8000;
    logic            acc_now;

    int n_checks = 0;
    int n_errors = 0;

    delay_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    assign mem_if.mem_rvalid = auto_ret ? auto_rvalid : man_rvalid;
    assign mem_if.mem_rdata  = auto_ret ? auto_rdata  : man_rdata;

    delay_mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MAX_READS    (MAXR),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .current_pipeline (current_pipeline),
        .req              (req),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .gnt              (gnt),
        .rvalid           (rvalid),
        .rdata            (rdata),
        .mem              (mem_if),
        .err_spurious     (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    // Memory responder: returns each accepted read one cycle later when enabled.
    always @(posedge clk) begin
        acc_now = mem_if.mem_req && mem_if.mem_ready && !mem_if.mem_we;
        #1;
        auto_rvalid = acc_now;
        auto_rdata  = ret_seq;
        if (acc_now) ret_seq = ret_seq + 16'd1;
    end

    // Reference model: state after the last edge, compared and then advanced at each negedge.
    bit            model_valid = 1'b0;
    bit            m_req, m_we, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [1:0]    m_rvalid;
    int            tagq[$];
    int            starve;
    int            mo_live, mo_stg, mo_win, mo_id;
    logic [1:0]    mo_el, mo_gnt;

    always @(negedge clk) begin
        mo_live = int'(current_pipeline);
        mo_stg  = 1 - mo_live;
        for (int i = 0; i < 2; i++) mo_el[i] = req[i] && (req_we[i] || tagq.size() < MAXR);
        mo_win = -1;
        if (!reset && (!m_req || mem_if.mem_ready)) begin
            if (mo_el[mo_live] && mo_el[mo_stg]) mo_win = (starve == LIMIT) ? mo_stg : mo_live;
            else if (mo_el[mo_live])             mo_win = mo_live;
            else if (mo_el[mo_stg])              mo_win = mo_stg;
        end
        mo_gnt = (mo_win < 0) ? 2'b00 : 2'(1 << mo_win);

        if (model_valid) begin
            check("model gnt", gnt, mo_gnt);
            check("model mem_req", mem_if.mem_req, m_req);
            if (m_req) begin
                check("model mem_we", mem_if.mem_we, m_we);
                check("model mem_addr", mem_if.mem_addr, m_addr);
                check("model mem_wdata", mem_if.mem_wdata, m_wdata);
            end
            check("model rvalid", rvalid, m_rvalid);
            check("model err_spurious", err_spurious, m_err);
            if (m_rvalid != 2'b00) check("model rdata", rdata, m_rdata);
        end

        if (reset) begin
            m_req = 0; m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0;
            m_rvalid = 2'b00; m_rdata = '0; starve = 0;
            tagq.delete();
            model_valid = 1'b1;
        end else begin
            m_rvalid = 2'b00;
            m_err    = 1'b0;
            if (mem_if.mem_rvalid) begin
                if (tagq.size() > 0) begin
                    mo_id    = tagq.pop_front();
                    m_rvalid = 2'(1 << mo_id);
                    m_rdata  = mem_if.mem_rdata;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (mo_win >= 0) begin
                m_req   = 1'b1;
                m_we    = req_we[mo_win];
                m_addr  = req_addr[mo_win*AW +: AW];
                m_wdata = req_wdata[mo_win*DW +: DW];
                if (!req_we[mo_win]) tagq.push_back(mo_win);
            end else if (mem_if.mem_ready) begin
                m_req = 1'b0;
            end
            if (req[mo_stg] && mo_win != mo_stg) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else                                 starve = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [1:0]    t4_pipe [4];
    logic [DW-1:0] t4_data [4];
    int            stg_idx[$];

    initial begin
        t4_pipe = '{2'b01, 2'b10, 2'b10, 2'b01};
        t4_data = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        mem_if.mem_ready = 1'b0;

        // Reset state
        repeat (3) next_cycle();
        at_sample();
        check("reset mem_req", mem_if.mem_req, 1'b0);
        check("reset mem_addr", mem_if.mem_addr, 24'h0);
        check("reset gnt", gnt, 2'b00);
        check("reset rvalid", rvalid, 2'b00);
        check("reset rdata", rdata, 16'h0);
        check("reset err_spurious", err_spurious, 1'b0);
        next_cycle();
        reset = 1'b0;
        repeat (2) next_cycle();

        // 1: starvation guard with both pipelines reading every cycle
        current_pipeline = 1'b0;
        mem_if.mem_ready = 1'b1;
        auto_ret = 1'b1;
        req = 2'b11; req_we = 2'b00;
        req_addr = {24'h000200, 24'h000100};
        for (int c = 0; c < 40; c++) begin
            at_sample();
            if (gnt == 2'b10) stg_idx.push_back(c);
            if (c == 15 || c == 17) check("t1 live grant", gnt, 2'b01);
            next_cycle();
        end
        check("t1 staging grant count", stg_idx.size(), 2);
        if (stg_idx.size() >= 2) begin
            check("t1 first staging grant cycle", stg_idx[0], 16);
            check("t1 second staging grant cycle", stg_idx[1], 33);
        end
        req = 2'b00;
        repeat (4) next_cycle();
        auto_ret = 1'b0;
        next_cycle();

        // 2: write held stable through a 3-cycle stall
        req = 2'b01; req_we = 2'b01;
        req_addr = {24'h0, 24'h000010};
        req_wdata = {16'h0, 16'h1234};
        at_sample();
        check("t2 write grant", gnt, 2'b01);
        next_cycle();
        req = 2'b00; req_we = 2'b00;
        mem_if.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            at_sample();
            check("t2 stall mem_req", mem_if.mem_req, 1'b1);
            check("t2 stall mem_addr", mem_if.mem_addr, 24'h000010);
            check("t2 stall mem_wdata", mem_if.mem_wdata, 16'h1234);
            check("t2 stall no gnt", gnt, 2'b00);
            next_cycle();
        end
        mem_if.mem_ready = 1'b1;
        at_sample();
        check("t2 accept mem_req", mem_if.mem_req, 1'b1);
        next_cycle();
        at_sample();
        check("t2 slot released", mem_if.mem_req, 1'b0);
        next_cycle();

        // 3: tag FIFO full blocks reads only
        req = 2'b10; req_we = 2'b00;
        for (int i = 0; i < MAXR; i++) begin
            req_addr = {24'h000300 + 24'(i), 24'h0};
            at_sample();
            check("t3 read grant", gnt, 2'b10);
            next_cycle();
        end
        at_sample();
        check("t3 ninth read blocked", gnt, 2'b00);
        next_cycle();
        req = 2'b11; req_we = 2'b01;
        req_addr = {24'h000308, 24'h000020};
        req_wdata = {16'h0, 16'hBEEF};
        at_sample();
        check("t3 write while full", gnt, 2'b01);
        next_cycle();
        req = 2'b10; req_we = 2'b00;
        man_rvalid = 1'b1; man_rdata = 16'h0055;
        at_sample();
        check("t3 full with pop refuses", gnt, 2'b00);
        next_cycle();
        man_rvalid = 1'b0;
        at_sample();
        check("t3 freed slot grant", gnt, 2'b10);
        check("t3 return rvalid", rvalid, 2'b10);
        check("t3 return rdata", rdata, 16'h0055);
        next_cycle();
        req = 2'b00;
        for (int k = 0; k < MAXR; k++) begin
            man_rvalid = 1'b1; man_rdata = 16'h0060 + 16'(k);
            next_cycle();
        end
        man_rvalid = 1'b0;
        repeat (2) next_cycle();

        // 4: interleaved reads routed back by tag
        req_we = 2'b00;
        for (int k = 0; k < 4; k++) begin
            req = t4_pipe[k];
            req_addr = (k == 1 || k == 2) ? {24'h000200 + 24'(k), 24'h0} : {24'h0, 24'h000100 + 24'(k)};
            at_sample();
            check("t4 grant", gnt, t4_pipe[k]);
            next_cycle();
        end
        req = 2'b00;
        repeat (2) next_cycle();
        man_rvalid = 1'b1; man_rdata = t4_data[0];
        at_sample();
        check("t4 rvalid latency", rvalid, 2'b00);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k < 3) man_rdata = t4_data[k+1];
            else       man_rvalid = 1'b0;
            at_sample();
            check("t4 rvalid route", rvalid, t4_pipe[k]);
            check("t4 rdata", rdata, t4_data[k]);
        end
        next_cycle();
        at_sample();
        check("t4 rvalid idle", rvalid, 2'b00);
        next_cycle();

        // 5: spurious return
        man_rvalid = 1'b1; man_rdata = 16'h0077;
        next_cycle();
        man_rvalid = 1'b0;
        at_sample();
        check("t5 err_spurious pulse", err_spurious, 1'b1);
        check("t5 no rvalid", rvalid, 2'b00);
        next_cycle();
        at_sample();
        check("t5 err_spurious clears", err_spurious, 1'b0);
        next_cycle();

        // 6: reset with reads outstanding
        req_we = 2'b00;
        for (int k = 0; k < 3; k++) begin
            req = 2'b01;
            req_addr = {24'h0, 24'h000400 + 24'(k)};
            at_sample();
            check("t6 read grant", gnt, 2'b01);
            next_cycle();
        end
        req = 2'b00;
        next_cycle();
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        at_sample();
        check("t6 mem_req", mem_if.mem_req, 1'b0);
        check("t6 mem_we", mem_if.mem_we, 1'b0);
        check("t6 mem_addr", mem_if.mem_addr, 24'h0);
        check("t6 mem_wdata", mem_if.mem_wdata, 16'h0);
        check("t6 rdata", rdata, 16'h0);
        check("t6 rvalid", rvalid, 2'b00);
        check("t6 gnt", gnt, 2'b00);
        next_cycle();
        man_rvalid = 1'b1; man_rdata = 16'h0099;
        next_cycle();
        man_rvalid = 1'b0;
        at_sample();
        check("t6 late return err_spurious", err_spurious, 1'b1);
        check("t6 late return no rvalid", rvalid, 2'b00);
        repeat (2) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
